// File: rtl/bid_agent_pkg.sv
// rtl/bid_agent_pkg.sv - shared types for the bidder-side auction endpoint
package bid_agent_pkg;

    typedef enum logic [1:0] {
        CERR_NONE     = 2'd0,
        CERR_INACTIVE = 2'd1,
        CERR_FUNDS    = 2'd2,
        CERR_INVALID  = 2'd3
    } ctrl_err_t;

    typedef enum logic [2:0] {
        RSP_OK           = 3'd0,
        RSP_ERR_INACTIVE = 3'd1,
        RSP_ERR_FUNDS    = 3'd2,
        RSP_ERR_INVALID  = 3'd3,
        RSP_TIMEOUT      = 3'd4,
        RSP_ABORT        = 3'd5,
        RSP_LOCAL_REJ    = 3'd6
    } rsp_code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } agent_state_t;

    function automatic rsp_code_t err_to_rsp(input ctrl_err_t e);
        case (e)
            CERR_INACTIVE: return RSP_ERR_INACTIVE;
            CERR_FUNDS:    return RSP_ERR_FUNDS;
            default:       return RSP_ERR_INVALID;
        endcase
    endfunction

endpackage

// File: rtl/bid_agent_if.sv
// rtl/bid_agent_if.sv - local request/response and controller port bundle
interface bid_agent_if #(
    parameter int AMT_W = 16,
    parameter int BAL_W = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_kind;
    logic [AMT_W-1:0] req_amt;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [2:0]       rsp_code;
    logic             bid;
    logic             retract;
    logic [AMT_W-1:0] bidAmt;
    logic             ack;
    logic [1:0]       err;
    logic [BAL_W-1:0] balance;
    logic             win;
    logic             roundOver;
    logic [BAL_W-1:0] maxBid;
    logic             round_done;
    logic             won;
    logic [BAL_W-1:0] last_balance;
    logic [BAL_W-1:0] last_maxBid;

    modport master (
        input  req_valid, req_kind, req_amt, rsp_ready,
        input  ack, err, balance, win, roundOver, maxBid,
        output req_ready, rsp_valid, rsp_code, bid, retract, bidAmt,
        output round_done, won, last_balance, last_maxBid
    );

    modport slave (
        output req_valid, req_kind, req_amt, rsp_ready,
        output ack, err, balance, win, roundOver, maxBid,
        input  req_ready, rsp_valid, rsp_code, bid, retract, bidAmt,
        input  round_done, won, last_balance, last_maxBid
    );
endinterface

// File: rtl/bid_agent.sv
// rtl/bid_agent.sv - bidder endpoint: issues bid/retract, resolves status, snapshots round end
module bid_agent
    import bid_agent_pkg::*;
#(
    parameter int AMT_W       = 16,
    parameter int BAL_W       = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    bid_agent_if.master  bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    agent_state_t     state_q, state_d;
    logic             kind_q;
    logic [AMT_W-1:0] amt_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    rsp_code_t        code_q, code_d;
    logic             has_bid_q;
    logic             ro_q;
    logic             round_done_q;
    logic             won_q;
    logic [BAL_W-1:0] last_balance_q;
    logic [BAL_W-1:0] last_maxbid_q;

    logic             latch_req;
    logic             has_bid_set;
    logic             has_bid_clr;
    logic             ro_rise;
    logic             local_rej;

    assign ro_rise   = bus.roundOver && !ro_q;
    assign local_rej = (!bus.req_kind && (bus.req_amt == '0)) || (bus.req_kind && !has_bid_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        code_d      = code_q;
        latch_req   = 1'b0;
        has_bid_set = 1'b0;
        has_bid_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    latch_req = 1'b1;
                    if (local_rej) begin
                        code_d  = RSP_LOCAL_REJ;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Error outranks a simultaneous ack: the controller rejected the request.
                if (ctrl_err_t'(bus.err) != CERR_NONE) begin
                    code_d  = err_to_rsp(ctrl_err_t'(bus.err));
                    state_d = ST_RESP;
                end else if (bus.ack) begin
                    code_d      = RSP_OK;
                    has_bid_set = !kind_q;
                    has_bid_clr = kind_q;
                    state_d     = ST_RESP;
                end else if (ro_rise) begin
                    code_d  = RSP_ABORT;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    code_d  = RSP_TIMEOUT;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            kind_q         <= 1'b0;
            amt_q          <= '0;
            cnt_q          <= '0;
            code_q         <= RSP_OK;
            has_bid_q      <= 1'b0;
            ro_q           <= 1'b0;
            round_done_q   <= 1'b0;
            won_q          <= 1'b0;
            last_balance_q <= '0;
            last_maxbid_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            code_q       <= code_d;
            ro_q         <= bus.roundOver;
            round_done_q <= ro_rise;
            if (latch_req) begin
                kind_q <= bus.req_kind;
                amt_q  <= bus.req_amt;
            end
            // Round end invalidates any standing bid, even one acked this cycle.
            if (ro_rise)          has_bid_q <= 1'b0;
            else if (has_bid_set) has_bid_q <= 1'b1;
            else if (has_bid_clr) has_bid_q <= 1'b0;
            if (ro_rise) begin
                won_q          <= bus.win;
                last_balance_q <= bus.balance;
                last_maxbid_q  <= bus.maxBid;
            end
        end
    end

    assign bus.req_ready    = reset_n && (state_q == ST_IDLE);
    assign bus.rsp_valid    = (state_q == ST_RESP);
    assign bus.rsp_code     = code_q;
    assign bus.bid          = (state_q == ST_ISSUE) && !kind_q;
    assign bus.retract      = (state_q == ST_ISSUE) && kind_q;
    assign bus.bidAmt       = ((state_q == ST_ISSUE) && !kind_q) ? amt_q : '0;
    assign bus.round_done   = round_done_q;
    assign bus.won          = won_q;
    assign bus.last_balance = last_balance_q;
    assign bus.last_maxBid  = last_maxbid_q;

endmodule

// File: tb/tb_bid_agent.sv
// tb/tb_bid_agent.sv - directed self-checking bench for bid_agent
module tb_bid_agent;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bid_agent_if #(.AMT_W(16), .BAL_W(32)) bus ();

    bid_agent #(.AMT_W(16), .BAL_W(32), .TIMEOUT_CYC(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic kind, input logic [15:0] amt);
        bus.req_valid = 1'b1;
        bus.req_kind  = kind;
        bus.req_amt   = amt;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic accept_rsp();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.req_valid = 0; bus.req_kind = 0; bus.req_amt = 0; bus.rsp_ready = 0;
        bus.ack = 0; bus.err = 0; bus.balance = 0; bus.win = 0; bus.roundOver = 0; bus.maxBid = 0;
        tick(); tick();
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0", bus.req_ready); end
        checks++; if ({bus.rsp_valid, bus.bid, bus.retract, bus.round_done, bus.won} !== 5'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0", {bus.rsp_valid, bus.bid, bus.retract, bus.round_done, bus.won}); end
        checks++; if ({bus.bidAmt, bus.rsp_code, bus.last_balance, bus.last_maxBid} !== '0) begin errors++; $display("FAIL reset_values got nonzero"); end
        reset_n = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", bus.req_ready); end
    endtask

    task automatic test_local_reject();
        start_req(1'b1, 16'd0);
        checks++; if (bus.retract !== 1'b0) begin errors++; $display("FAIL rej_retract_pulse got=%b exp=0", bus.retract); end
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_code !== 3'd6) begin errors++; $display("FAIL rej_retract_rsp got=%b/%0d exp=1/6", bus.rsp_valid, bus.rsp_code); end
        accept_rsp();
        checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL rej_retract_done got=%b/%b exp=0/1", bus.rsp_valid, bus.req_ready); end
        start_req(1'b0, 16'd0);
        checks++; if (bus.bid !== 1'b0) begin errors++; $display("FAIL rej_bid0_pulse got=%b exp=0", bus.bid); end
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_code !== 3'd6) begin errors++; $display("FAIL rej_bid0_rsp got=%b/%0d exp=1/6", bus.rsp_valid, bus.rsp_code); end
        accept_rsp();
    endtask

    task automatic test_bid_ok();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.bid !== 1'b0) begin errors++; $display("FAIL idle_ack_ignored got=%b/%b exp=0/0", bus.rsp_valid, bus.bid); end
        start_req(1'b0, 16'd50);
        checks++; if (bus.bid !== 1'b1 || bus.bidAmt !== 16'd50 || bus.retract !== 1'b0) begin errors++; $display("FAIL bid_pulse got=%b/%0d/%b exp=1/50/0", bus.bid, bus.bidAmt, bus.retract); end
        tick();
        checks++; if (bus.bid !== 1'b0 || bus.bidAmt !== 16'd0) begin errors++; $display("FAIL bid_pulse_width got=%b/%0d exp=0/0", bus.bid, bus.bidAmt); end
        tick(); tick();
        bus.ack = 1'b1;
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bid_early_rsp got=%b exp=0", bus.rsp_valid); end
        tick();
        bus.ack = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_code !== 3'd0) begin errors++; $display("FAIL bid_ok_rsp got=%b/%0d exp=1/0", bus.rsp_valid, bus.rsp_code); end
        accept_rsp();
        checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL bid_ok_done got=%b/%b exp=0/1", bus.rsp_valid, bus.req_ready); end
    endtask

    task automatic test_retract_ok();
        start_req(1'b1, 16'd77);
        checks++; if (bus.retract !== 1'b1 || bus.bid !== 1'b0 || bus.bidAmt !== 16'd0) begin errors++; $display("FAIL retract_pulse got=%b/%b/%0d exp=1/0/0", bus.retract, bus.bid, bus.bidAmt); end
        tick();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_code !== 3'd0) begin errors++; $display("FAIL retract_ok_rsp got=%b/%0d exp=1/0", bus.rsp_valid, bus.rsp_code); end
        accept_rsp();
    endtask

    task automatic test_err_funds();
        start_req(1'b0, 16'd500);
        checks++; if (bus.bid !== 1'b1 || bus.bidAmt !== 16'd500) begin errors++; $display("FAIL funds_pulse got=%b/%0d exp=1/500", bus.bid, bus.bidAmt); end
        tick();
        bus.ack = 1'b1; bus.err = 2'b10;
        tick();
        bus.ack = 1'b0; bus.err = 2'b00;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_code !== 3'd2) begin errors++; $display("FAIL funds_rsp got=%b/%0d exp=1/2", bus.rsp_valid, bus.rsp_code); end
        accept_rsp();
        start_req(1'b1, 16'd0);
        checks++; if (bus.retract !== 1'b0 || bus.rsp_code !== 3'd6) begin errors++; $display("FAIL funds_no_has_bid got=%b/%0d exp=0/6", bus.retract, bus.rsp_code); end
        accept_rsp();
    endtask

    task automatic test_timeout();
        start_req(1'b0, 16'd9);
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 0 || i == 15) begin
                checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL timeout_early wait=%0d got=%b exp=0", i + 1, bus.rsp_valid); end
            end
        end
        tick();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_code !== 3'd4) begin errors++; $display("FAIL timeout_rsp got=%b/%0d exp=1/4", bus.rsp_valid, bus.rsp_code); end
        for (int i = 0; i < 5; i++) begin
            bus.ack = (i == 2);
            tick();
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_code !== 3'd4) begin errors++; $display("FAIL timeout_hold cyc=%0d got=%b/%0d exp=1/4", i, bus.rsp_valid, bus.rsp_code); end
        end
        bus.ack = 1'b0;
        accept_rsp();
        checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL timeout_clear got=%b/%b exp=0/1", bus.rsp_valid, bus.req_ready); end
    endtask

    task automatic test_abort();
        start_req(1'b0, 16'd20);
        tick();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        accept_rsp();
        bus.win = 1'b1; bus.balance = 32'd900; bus.maxBid = 32'd75;
        start_req(1'b0, 16'd30);
        tick();
        bus.roundOver = 1'b1;
        tick();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_code !== 3'd5) begin errors++; $display("FAIL abort_rsp got=%b/%0d exp=1/5", bus.rsp_valid, bus.rsp_code); end
        checks++; if (bus.round_done !== 1'b1) begin errors++; $display("FAIL abort_round_done got=%b exp=1", bus.round_done); end
        checks++; if (bus.won !== 1'b1 || bus.last_balance !== 32'd900 || bus.last_maxBid !== 32'd75) begin errors++; $display("FAIL abort_capture got=%b/%0d/%0d exp=1/900/75", bus.won, bus.last_balance, bus.last_maxBid); end
        bus.win = 1'b0; bus.balance = 32'd1; bus.maxBid = 32'd2;
        accept_rsp();
        checks++; if (bus.round_done !== 1'b0) begin errors++; $display("FAIL abort_round_done_width got=%b exp=0", bus.round_done); end
        checks++; if (bus.won !== 1'b1 || bus.last_balance !== 32'd900 || bus.last_maxBid !== 32'd75) begin errors++; $display("FAIL abort_persist got=%b/%0d/%0d exp=1/900/75", bus.won, bus.last_balance, bus.last_maxBid); end
        start_req(1'b1, 16'd0);
        checks++; if (bus.retract !== 1'b0 || bus.rsp_code !== 3'd6) begin errors++; $display("FAIL abort_clears_has_bid got=%b/%0d exp=0/6", bus.retract, bus.rsp_code); end
        accept_rsp();
        bus.roundOver = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        start_req(1'b0, 16'd40);
        tick(); tick();
        reset_n = 1'b0;
        tick();
        checks++; if ({bus.req_ready, bus.rsp_valid, bus.bid, bus.retract, bus.round_done, bus.won} !== 6'b0) begin errors++; $display("FAIL midreset_flags got=%b exp=0", {bus.req_ready, bus.rsp_valid, bus.bid, bus.retract, bus.round_done, bus.won}); end
        checks++; if (bus.last_balance !== 32'd0 || bus.last_maxBid !== 32'd0 || bus.rsp_code !== 3'd0) begin errors++; $display("FAIL midreset_values got=%0d/%0d/%0d exp=0/0/0", bus.last_balance, bus.last_maxBid, bus.rsp_code); end
        reset_n = 1'b1;
        bus.ack = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got=%b exp=1", bus.req_ready); end
        tick(); tick();
        bus.ack = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL midreset_stale got=%b/%b exp=0/1", bus.rsp_valid, bus.req_ready); end
    endtask

    initial begin
        test_reset();
        test_local_reject();
        test_bid_ok();
        test_retract_ok();
        test_err_funds();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
